// File: rtl/keystream_job_arbiter.sv
// keystream_job_arbiter
// Two requesters take turns on one 20-bit LFSR masking datapath. A granted
// job streams its captured 128-bit key as NBEAT 64-bit beats. Each key bit is
// widened to eight copies and XORed with the matching LFSR bit. The beats go
// out over a valid/ready handshake.
module keystream_job_arbiter #(
    parameter int NBEAT  = 16,
    parameter bit RESEED = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   req,
    input  logic [127:0] key0,
    input  logic [127:0] key1,
    output logic [1:0]   gnt,
    output logic [1:0]   done,
    output logic         busy,
    output logic [63:0]  load,
    output logic         load_valid,
    input  logic         load_ready,
    output logic [3:0]   beat_idx
);

    localparam logic [19:0] SEED      = 20'h99999;
    localparam logic [3:0]  LAST_BEAT = 4'(NBEAT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_reg;
    state_t         state_next;
    logic [1:0]     gnt_reg;
    logic [127:0]   key_reg;
    logic           last_reg;
    logic [3:0]     beat_idx_reg;
    logic           load_valid_reg;
    logic [19:0]    lfsr_reg;

    logic           grant_fire;
    logic           beat_step;
    logic           job_finish;
    logic           winner;
    logic [19:0]    lfsr_next;
    logic [63:0]    mask_bits;

    // Feedback taps 15/11/7/0; new bit enters at the top and the register shifts right.
    assign lfsr_next = {lfsr_reg[15] ^ lfsr_reg[11] ^ lfsr_reg[7] ^ lfsr_reg[0],
                        lfsr_reg[19:1]};

    // Round-robin pick: the requester other than the last winner has priority.
    always_comb begin
        if (last_reg) begin
            winner = req[0] ? 1'b0 : 1'b1;
        end else begin
            winner = req[1] ? 1'b1 : 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic and the datapath control strobes.
    always_comb begin
        state_next = state_reg;
        grant_fire = 1'b0;
        beat_step  = 1'b0;
        job_finish = 1'b0;
        case (state_reg)
            IDLE: begin
                if (|req) begin
                    grant_fire = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (load_valid_reg && load_ready) begin
                    if (beat_idx_reg == LAST_BEAT) begin
                        job_finish = 1'b1;
                        state_next = DONE;
                    end else begin
                        beat_step = 1'b1;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Job datapath: grant capture, beat advance, LFSR stepping and grant release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_reg        <= 2'b00;
            key_reg        <= '0;
            last_reg       <= 1'b1;
            beat_idx_reg   <= 4'd0;
            load_valid_reg <= 1'b0;
            lfsr_reg       <= SEED;
        end else begin
            if (grant_fire) begin
                gnt_reg        <= winner ? 2'b10 : 2'b01;
                key_reg        <= winner ? key1 : key0;
                last_reg       <= winner;
                beat_idx_reg   <= 4'd0;
                load_valid_reg <= 1'b1;
                if (RESEED) begin
                    lfsr_reg <= SEED;
                end
            end
            // The LFSR advances only between beats of a job, so a stalled or
            // idle arbiter keeps the mask frozen.
            if (beat_step) begin
                beat_idx_reg <= beat_idx_reg + 4'd1;
                lfsr_reg     <= lfsr_next;
            end
            if (job_finish) begin
                load_valid_reg <= 1'b0;
            end
            if (state_reg == DONE) begin
                gnt_reg <= 2'b00;
            end
        end
    end

    // Each output bit i takes key bit 8*beat_idx + i/8 and LFSR bit i/8.
    generate
        for (genvar gi = 0; gi < 64; gi++) begin : g_bit
            localparam logic [2:0] SUB = 3'(gi / 8);
            assign mask_bits[gi] = key_reg[{beat_idx_reg, SUB}] ^ lfsr_reg[SUB];
        end
    endgenerate

    assign gnt        = gnt_reg;
    assign done       = (state_reg == DONE) ? gnt_reg : 2'b00;
    assign busy       = (state_reg != IDLE);
    assign load_valid = load_valid_reg;
    assign beat_idx   = beat_idx_reg;
    assign load       = load_valid_reg ? mask_bits : 64'd0;

endmodule

// File: doc/keystream_job_arbiter.md
# keystream_job_arbiter

Round-robin controller that shares one 20-bit LFSR masking datapath between two requesters. Each granted job streams a 128-bit key out as 64-bit masked beats: each key bit is expanded eight-fold and XORed with the LFSR. Output uses a valid/ready handshake. The block sits between the key-holding requesters and the downstream consumer of the masked `load` bus.

## Interface
Parameters:
- `NBEAT`, 16: beats per job, legal 1..16. Beat b consumes key bits [8b+7:8b].
- `RESEED`, 1: 1 = LFSR reloads its seed at every grant; 0 = LFSR free-continues across jobs.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  2  per-requester job request, level.
- `key0`  in  128  requester 0 key, sampled at grant.
- `key1`  in  128  requester 1 key, sampled at grant.
- `gnt`  out  2  one-hot grant, registered, held for the whole job.
- `done`  out  2  one-cycle pulse to the granted requester after its last beat.
- `busy`  out  1  high in RUN and DONE.
- `load`  out  64  masked beat; 0 whenever `load_valid`=0.
- `load_valid`  out  1  beat valid.
- `load_ready`  in  1  consumer accepts beat.
- `beat_idx`  out  4  index of the current beat.

## Operation
- LFSR `lfsr_q[19:0]`: seed 20'h99999. Step: `lfsr_q <= {d0, lfsr_q[19:1]}` with `d0 = lfsr_q[15]^lfsr_q[11]^lfsr_q[7]^lfsr_q[0]`.
- Beat function, for i in 0..63: `load[i] = key_q[8*beat_idx + i/8] ^ lfsr_q[i/8]`. Combinational from registers, gated by `load_valid`.
- FSM states are IDLE, RUN and DONE.
- IDLE, with any `req` bit set:
  - Arbitrate round-robin. Pointer `last` starts at 1, so requester 0 wins first.
  - The winner is the requester not equal to `last` if it requests, otherwise the only requester.
  - At the edge: set `gnt`, capture that requester's key into `key_q`, set `last` to the winner, clear `beat_idx`, set `load_valid`=1, go to RUN.
  - If RESEED=1, load the seed into the LFSR at the same edge.
- RUN, on each edge with `load_valid & load_ready`:
  - If `beat_idx`=NBEAT-1: clear `load_valid`, go to DONE.
  - Otherwise: increment `beat_idx` and step the LFSR once.
  - The LFSR steps only on accepted non-final beats. It never steps while stalled or idle.
- DONE lasts exactly one cycle. It drives `done[winner]`=1 and keeps `gnt`. At the next edge it clears `gnt` and goes to IDLE.
- Deasserting `req` mid-job is ignored; the job always completes.
- Changes to `key0`/`key1` after the grant have no effect.

## Timing
- Reset (asynchronous, immediate) clears the following to 0: `gnt`, `done`, `busy`, `load_valid`, `load`, `beat_idx`.
  - Reset also sets `lfsr_q`=20'h99999, `last`=1 and state IDLE.
  - A reset mid-job aborts the job with no `done`.
- Grant latency: `req` high in IDLE at edge k → `gnt`, `busy` and `load_valid` high in cycle k+1. Beat 0 is on `load` in the same cycle.
- Throughput: one beat per cycle with `load_ready` held high. A job occupies NBEAT RUN cycles plus 1 DONE cycle.
- IDLE gap: at least one IDLE cycle between jobs. A waiting requester is granted at the edge leaving that IDLE cycle.
- Backpressure: while `load_ready`=0, `load`, `beat_idx` and `lfsr_q` are held stable.
- Simultaneous requests: grants alternate 0,1,0,1 when both requests are held.
- Wrap-around: LFSR has no special handling for the all-zero state. This state is unreachable from the seed.

## Test plan
- Reset, then `req`=01, `key0`=0, `load_ready`=1:
  - Cycle after grant: `gnt`=01, beat 0 `load`=64'hFF0000FFFF0000FF (lfsr 0x99999).
  - Next cycle: beat 1 `load`=64'hFFFF0000FFFF0000 (lfsr 0x4CCCC).
  - `done`=01 exactly one cycle after beat 15.
- `key0`=all ones, first job: beat 0 `load`=64'h00FFFF0000FFFF00, the bitwise inverse of the zero-key case.
- Backpressure: drop `load_ready` for 5 cycles during beat 3. `load`, `beat_idx`=3 and the LFSR stay constant; the job resumes at beat 3 and still produces 16 beats.
- `req`=11 held for three jobs: `gnt` sequence is 01, 10, 01. Each job is separated by DONE plus one IDLE cycle.
- RESEED=1: second job beat 0 equals first job beat 0 for equal keys. With RESEED=0, the second job beat 0 uses the LFSR state after 15 steps.
- Assert `rst` asynchronously at beat 7. All outputs go to 0 immediately and no `done` is issued. A new `req` gets a fresh job from beat 0, seed 0x99999.
